// File: rtl/task2_12_mux.sv
// task2_12_mux: 2:1 word mux with registered copy and saturating select-change counter
module task2_12_mux #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             s,
   input  logic             en,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             s_q,
   output logic [CNT_W-1:0] sel_changes
);
   logic s_prev;
   assign y = s ? d1 : d0;
   // s_prev tracks s every cycle so the counter sees transitions even while en is low
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q         <= '0;
         s_q         <= 1'b0;
         s_prev      <= 1'b0;
         sel_changes <= '0;
      end else begin
         if (en) begin
            y_q <= y;
            s_q <= s;
         end
         s_prev <= s;
         if (s != s_prev && sel_changes != '1) sel_changes <= sel_changes + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_task2_12_mux.sv
// tb_task2_12_mux: directed checks of the combinational, registered and counter paths
module tb_task2_12_mux;
   logic       clk = 1'b0;
   logic       rst = 1'b0, s = 1'b0, en = 1'b0;
   logic [3:0] d0 = '0, d1 = '0;
   logic [3:0] y, y_q, y2, y_q2;
   logic       s_q, s_q2;
   logic [7:0] sel_changes;
   logic [1:0] sel_changes2;
   int         n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   task2_12_mux #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .d0(d0), .d1(d1), .s(s), .en(en),
      .y(y), .y_q(y_q), .s_q(s_q), .sel_changes(sel_changes)
   );
   task2_12_mux #(.WIDTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .d0(d0), .d1(d1), .s(s), .en(en),
      .y(y2), .y_q(y_q2), .s_q(s_q2), .sel_changes(sel_changes2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // d0, d1, s, expected y
   logic [3:0] vec [8][4] = '{
      '{0,0,0,0}, '{0,0,1,0}, '{0,1,0,0}, '{0,1,1,1},
      '{1,0,0,1}, '{1,0,1,0}, '{1,1,0,1}, '{1,1,1,1}
   };

   initial begin
      for (int i = 0; i < 8; i++) begin
         d0 = vec[i][0]; d1 = vec[i][1]; s = vec[i][2][0];
         #10;
         chk($sformatf("comb%0d", i), 32'(y), 32'(vec[i][3]));
      end
      d0 = 4'hA; d1 = 4'h5; s = 1'b0;
      #2 chk("wide_s0", 32'(y), 32'hA);
      s = 1'b1;
      #2 chk("wide_s1", 32'(y), 32'h5);

      tick();
      rst = 1'b1; s = 1'b0;
      tick();
      chk("rst_y_q", 32'(y_q), 0);
      chk("rst_s_q", 32'(s_q), 0);
      chk("rst_cnt", 32'(sel_changes), 0);
      rst = 1'b0; en = 1'b1; d0 = 4'h3; d1 = 4'hC; s = 1'b1;
      tick();
      chk("load_y_q", 32'(y_q), 32'hC);
      chk("load_s_q", 32'(s_q), 1);
      en = 1'b0; d1 = 4'h7;
      tick();
      chk("hold_y_q", 32'(y_q), 32'hC);
      chk("hold_y", 32'(y), 32'h7);

      rst = 1'b1; s = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s = ~s;
         tick();
      end
      chk("cnt5", 32'(sel_changes), 5);
      chk("sat_after5", 32'(sel_changes2), 3);
      for (int i = 0; i < 3; i++) tick();
      chk("cnt_hold", 32'(sel_changes), 5);

      rst = 1'b1; s = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s = ~s;
         tick();
      end
      chk("sat_at3", 32'(sel_changes2), 3);
      for (int i = 0; i < 3; i++) begin
         s = ~s;
         tick();
      end
      chk("sat_nowrap", 32'(sel_changes2), 3);
      chk("cnt6", 32'(sel_changes), 6);

      en = 1'b1; rst = 1'b1; d0 = 4'h9; d1 = 4'h6; s = 1'b1;
      tick();
      chk("prio_y_q", 32'(y_q), 0);
      chk("prio_cnt", 32'(sel_changes), 0);
      chk("prio_y", 32'(y), 32'h6);
      rst = 1'b0;
      tick();
      chk("post_rst_cnt", 32'(sel_changes), 1);
      chk("post_rst_y_q", 32'(y_q), 32'h6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
